// File: rtl/pipe_hazard_ctrl_if.sv
// Event/control bundle between the core datapath and the hazard sequencer.
interface pipe_hazard_ctrl_if #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 32
);
    logic              ld_hazard_i;
    logic              jump_i;
    logic              mc_start_i;
    logic              mc_done_i;
    logic              trap_req_i;
    logic [STAGES-1:0] ld_en_o;
    logic [STAGES-1:0] flush_o;
    logic              pc_hold_o;
    logic              trap_ack_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output ld_hazard_i, jump_i, mc_start_i, mc_done_i, trap_req_i,
        input  ld_en_o, flush_o, pc_hold_o, trap_ack_o, stall_cnt_o
    );

    modport slave (
        input  ld_hazard_i, jump_i, mc_start_i, mc_done_i, trap_req_i,
        output ld_en_o, flush_o, pc_hold_o, trap_ack_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the pipeline registers (IF/ID .. MEM/WB).
// Optional MC_WAIT watchdog enabled by defining STALL_WATCHDOG_EN.
module pipe_hazard_ctrl #(
    parameter int STAGES     = 4,
    parameter int JUMP_FLUSH = 2,
    parameter int CNT_W      = 32
`ifdef STALL_WATCHDOG_EN
    ,
    parameter int WD_LIMIT   = 64
`endif
) (
    input  logic clk,
    input  logic rst_n,
    pipe_hazard_ctrl_if.slave hz
`ifdef STALL_WATCHDOG_EN
    ,
    output logic wd_err_o
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        JFLUSH  = 2'd1,
        MC_WAIT = 2'd2,
        TRAP    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  scnt_q;
    logic [STAGES-1:0] ld_en, flush;
    logic              hold;
    logic              wd_hit;
    logic              mc_fin;

    logic ev_trap, ev_jump, ev_mc, ev_haz;

`ifdef STALL_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);
    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_err_q;

    assign wd_hit = (state_q == MC_WAIT)
                 && (wd_cnt_q == WD_W'(WD_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            if (state_q == MC_WAIT && !mc_fin)
                wd_cnt_q <= wd_cnt_q + 1'b1;
            else
                wd_cnt_q <= '0;
            if (wd_hit)
                wd_err_q <= 1'b1;
        end
    end

    assign wd_err_o = wd_err_q;
`else
    assign wd_hit = 1'b0;
`endif

    assign mc_fin = hz.mc_done_i | wd_hit;

    // RUN-state priority: trap > jump > multi-cycle > load-use
    assign ev_trap = hz.trap_req_i;
    assign ev_jump = !ev_trap && hz.jump_i;
    assign ev_mc   = !ev_trap && !hz.jump_i
                  && hz.mc_start_i && !hz.mc_done_i;
    assign ev_haz  = !ev_trap && !hz.jump_i
                  && !(hz.mc_start_i && !hz.mc_done_i)
                  && hz.ld_hazard_i;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        ld_en   = '1;
        flush   = '0;
        hold    = 1'b0;
        unique case (state_q)
            RUN: begin
                unique case (1'b1)
                    ev_trap: begin
                        flush   = '1;
                        hold    = 1'b1;
                        state_d = TRAP;
                    end
                    ev_jump: begin
                        flush[1:0] = 2'b11;
                        if (JUMP_FLUSH > 1) begin
                            fcnt_d  = 4'(JUMP_FLUSH - 1);
                            state_d = JFLUSH;
                        end
                    end
                    ev_mc: begin
                        ld_en[STAGES-2:0] = '0;
                        flush[STAGES-1]   = 1'b1;
                        hold              = 1'b1;
                        state_d           = MC_WAIT;
                    end
                    ev_haz: begin
                        ld_en[0] = 1'b0;
                        flush[1] = 1'b1;
                        hold     = 1'b1;
                    end
                    default: ;
                endcase
            end
            JFLUSH: begin
                if (hz.trap_req_i) begin
                    flush   = '1;
                    hold    = 1'b1;
                    state_d = TRAP;
                end else begin
                    flush[1:0] = 2'b11;
                    fcnt_d     = fcnt_q - 4'd1;
                    if (fcnt_q <= 4'd1)
                        state_d = RUN;
                end
            end
            MC_WAIT: begin
                // Trap is deferred until the unit finishes.
                if (mc_fin) begin
                    state_d = hz.trap_req_i ? TRAP : RUN;
                end else begin
                    ld_en[STAGES-2:0] = '0;
                    flush[STAGES-1]   = 1'b1;
                    hold              = 1'b1;
                end
            end
            TRAP: begin
                flush   = '1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (hold && scnt_q != '1)
                scnt_q <= scnt_q + 1'b1;
        end
    end

    assign hz.ld_en_o     = ld_en;
    assign hz.flush_o     = flush;
    assign hz.pc_hold_o   = hold;
    assign hz.trap_ack_o  = (state_q == TRAP);
    assign hz.stall_cnt_o = scnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (STAGES=4, JUMP_FLUSH=2).
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n;
`ifdef STALL_WATCHDOG_EN
    logic wd_err;
`endif

    pipe_hazard_ctrl_if #(.STAGES(4), .CNT_W(32)) hz ();

    pipe_hazard_ctrl #(
        .STAGES(4),
        .JUMP_FLUSH(2),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hz(hz)
`ifdef STALL_WATCHDOG_EN
        ,
        .wd_err_o(wd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [3:0] e_ld,
                       input logic [3:0] e_fl,
                       input logic e_hold,
                       input logic e_ack);
        checks++;
        assert (hz.ld_en_o === e_ld) else begin
            errors++;
            $error("FAIL %s ld_en got %b exp %b", tag, hz.ld_en_o, e_ld);
        end
        checks++;
        assert (hz.flush_o === e_fl) else begin
            errors++;
            $error("FAIL %s flush got %b exp %b", tag, hz.flush_o, e_fl);
        end
        checks++;
        assert (hz.pc_hold_o === e_hold) else begin
            errors++;
            $error("FAIL %s pc_hold got %b exp %b", tag, hz.pc_hold_o, e_hold);
        end
        checks++;
        assert (hz.trap_ack_o === e_ack) else begin
            errors++;
            $error("FAIL %s trap_ack got %b exp %b", tag, hz.trap_ack_o, e_ack);
        end
    endtask

    task automatic chk_cnt(input string tag, input int e);
        checks++;
        assert (hz.stall_cnt_o === 32'(e)) else begin
            errors++;
            $error("FAIL %s stall_cnt got %0d exp %0d", tag, hz.stall_cnt_o, e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        hz.ld_hazard_i = 1'b0;
        hz.jump_i      = 1'b0;
        hz.mc_start_i  = 1'b0;
        hz.mc_done_i   = 1'b0;
        hz.trap_req_i  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset", 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk_cnt("reset_cnt", 0);

        // load-use hazard
        @(negedge clk);
        hz.ld_hazard_i = 1'b1;
        #1 chk("haz", 4'b1110, 4'b0010, 1'b1, 1'b0);
        @(negedge clk);
        hz.ld_hazard_i = 1'b0;
        #1 chk("haz_after", 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk_cnt("haz_cnt", 1);

        // jump with concurrent hazard
        @(negedge clk);
        hz.jump_i      = 1'b1;
        hz.ld_hazard_i = 1'b1;
        #1 chk("jump0", 4'b1111, 4'b0011, 1'b0, 1'b0);
        @(negedge clk);
        hz.jump_i = 1'b0;
        #1 chk("jump1", 4'b1111, 4'b0011, 1'b0, 1'b0);
        @(negedge clk);
        hz.ld_hazard_i = 1'b0;
        #1 chk("jump_end", 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk_cnt("jump_cnt", 1);

        // multi-cycle op, done 5 cycles after start
        @(negedge clk);
        hz.mc_start_i = 1'b1;
        #1 chk("mc0", 4'b1000, 4'b1000, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            hz.mc_start_i = 1'b0;
            hz.jump_i     = (i == 2);
            #1 chk("mc_wait", 4'b1000, 4'b1000, 1'b1, 1'b0);
        end
        @(negedge clk);
        hz.jump_i    = 1'b0;
        hz.mc_done_i = 1'b1;
        #1 chk("mc_done", 4'b1111, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        hz.mc_done_i = 1'b0;
        #1 chk("mc_after", 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk_cnt("mc_cnt", 6);

        // trap raised during MC_WAIT is deferred
        @(negedge clk);
        hz.mc_start_i = 1'b1;
        #1 chk("mct0", 4'b1000, 4'b1000, 1'b1, 1'b0);
        @(negedge clk);
        hz.mc_start_i = 1'b0;
        hz.trap_req_i = 1'b1;
        #1 chk("mct1", 4'b1000, 4'b1000, 1'b1, 1'b0);
        @(negedge clk);
        #1 chk("mct2", 4'b1000, 4'b1000, 1'b1, 1'b0);
        @(negedge clk);
        hz.mc_done_i = 1'b1;
        #1 chk("mct_done", 4'b1111, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        hz.mc_done_i = 1'b0;
        #1 chk("mct_trap", 4'b1111, 4'b1111, 1'b0, 1'b1);
        @(negedge clk);
        hz.trap_req_i = 1'b0;
        #1 chk("mct_run", 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk_cnt("mct_cnt", 9);

        // trap from RUN, beating a simultaneous jump
        @(negedge clk);
        hz.trap_req_i = 1'b1;
        hz.jump_i     = 1'b1;
        #1 chk("trap_req", 4'b1111, 4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        hz.jump_i = 1'b0;
        #1 chk("trap_ack", 4'b1111, 4'b1111, 1'b0, 1'b1);
        @(negedge clk);
        hz.trap_req_i = 1'b0;
        #1 chk("trap_run", 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk_cnt("trap_cnt", 10);

        // zero-wait multi-cycle op and stray done
        @(negedge clk);
        hz.mc_start_i = 1'b1;
        hz.mc_done_i  = 1'b1;
        #1 chk("mc_zero", 4'b1111, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        hz.mc_start_i = 1'b0;
        #1 chk("mc_stray", 4'b1111, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        hz.mc_done_i = 1'b0;
        #1 chk("mc_zero_run", 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk_cnt("zero_cnt", 10);

        // trap during the jump flush window
        @(negedge clk);
        hz.jump_i = 1'b1;
        #1 chk("jt0", 4'b1111, 4'b0011, 1'b0, 1'b0);
        @(negedge clk);
        hz.jump_i     = 1'b0;
        hz.trap_req_i = 1'b1;
        #1 chk("jt_trap", 4'b1111, 4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        #1 chk("jt_ack", 4'b1111, 4'b1111, 1'b0, 1'b1);
        @(negedge clk);
        hz.trap_req_i = 1'b0;
        #1 chk("jt_run", 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk_cnt("jt_cnt", 11);

        // reset in the middle of a stall
        @(negedge clk);
        hz.mc_start_i = 1'b1;
        @(negedge clk);
        hz.mc_start_i = 1'b0;
        #1 chk("rst_pre", 4'b1000, 4'b1000, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst_mid", 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk_cnt("rst_mid_cnt", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("rst_post", 4'b1111, 4'b0000, 1'b0, 1'b0);

`ifdef STALL_WATCHDOG_EN
        checks++;
        assert (wd_err === 1'b0) else begin
            errors++;
            $error("FAIL wd_init got %b exp 0", wd_err);
        end
        @(negedge clk);
        hz.mc_start_i = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!hz.pc_hold_o) break;
            n++;
            @(negedge clk);
            hz.mc_start_i = 1'b0;
        end
        checks++;
        assert (n == 64) else begin
            errors++;
            $error("FAIL wd_hold_cycles got %0d exp 64", n);
        end
        repeat (3) @(negedge clk);
        #1 chk("wd_run", 4'b1111, 4'b0000, 1'b0, 1'b0);
        checks++;
        assert (wd_err === 1'b1) else begin
            errors++;
            $error("FAIL wd_sticky got %b exp 1", wd_err);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        assert (wd_err === 1'b0) else begin
            errors++;
            $error("FAIL wd_reset got %b exp 0", wd_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
`else
        n = 0;
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
